// File: rtl/nesctrl_pkg.sv
// Shared types and constants for the NES gamepad scanner.
// Optional debounce is enabled by defining NESCTRL_DEBOUNCE_EN.
package nesctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_CLK_HI,
        ST_CLK_LO,
        ST_DONE
    } nes_state_e;

    localparam int NESCTRL_NBITS       = 8;
    localparam int NESCTRL_LATCH_TICKS = 2;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nesctrl_scanner_tick_gen.sv
// Protocol prescaler: one-cycle tick every TICK_DIV clocks, held at
// zero while clear is high so the first tick of a scan is phase-aligned.
module nesctrl_tick_gen #(
    parameter int TICK_DIV = 600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(TICK_DIV - 1));
    assign tick = wrap && !clear;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nesctrl_scanner.sv
// Dual NES pad poller: latch, 7 shift clocks, 8 samples, publish.
// Define NESCTRL_DEBOUNCE_EN to publish only words stable over two scans.
module nesctrl_scanner
    import nesctrl_pkg::*;
#(
    parameter int TICK_DIV = 600,
    parameter int POLL_DIV = 1666667
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_req,
    input  logic       nesctrl_ctrl1_q7,
    input  logic       nesctrl_ctrl2_q7,
    output logic       nesctrl_pl1,
    output logic       nesctrl_pl2,
    output logic       nesctrl_clk1,
    output logic       nesctrl_clk2,
    output logic [7:0] ctrl1_data,
    output logic [7:0] ctrl2_data,
    output logic       data_valid,
    output logic       data_changed,
    output logic       busy
);

    localparam int PW = $clog2(POLL_DIV);
    localparam int BW = $clog2(NESCTRL_NBITS);
    localparam int LW = $clog2(NESCTRL_LATCH_TICKS);

    logic [1:0]    meta_q;
    logic [1:0]    sync_q;
    logic [PW-1:0] poll_cnt_q;
    logic [PW-1:0] poll_cnt_d;
    logic          poll_evt;
    logic          tick;

    nes_state_e    state_q, state_d;
    logic [LW-1:0] latch_cnt_q, latch_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    sr1_q, sr1_d, sr2_q, sr2_d;
    logic [7:0]    data1_q, data1_d, data2_q, data2_d;
    logic          pl_q, pl_d;
    logic          sclk_q, sclk_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          changed_q, changed_d;
    logic [7:0]    cap1, cap2, new1, new2;
`ifdef NESCTRL_DEBOUNCE_EN
    logic [7:0]    raw1_q, raw1_d, raw2_q, raw2_d;
`endif

    nesctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == ST_IDLE),
        .tick  (tick)
    );

    assign poll_evt   = (poll_cnt_q == PW'(POLL_DIV - 1));
    assign poll_cnt_d = poll_evt ? '0 : poll_cnt_q + PW'(1);

    always_comb begin
        // Current shift word with this tick's sample merged in
        cap1            = sr1_q;
        cap2            = sr2_q;
        cap1[bit_cnt_q] = ~sync_q[0];
        cap2[bit_cnt_q] = ~sync_q[1];
`ifdef NESCTRL_DEBOUNCE_EN
        new1   = (cap1 == raw1_q) ? cap1 : data1_q;
        new2   = (cap2 == raw2_q) ? cap2 : data2_q;
        raw1_d = raw1_q;
        raw2_d = raw2_q;
`else
        new1 = cap1;
        new2 = cap2;
`endif
        state_d     = state_q;
        latch_cnt_d = latch_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sr1_d       = sr1_q;
        sr2_d       = sr2_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        valid_d     = 1'b0;
        changed_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                latch_cnt_d = '0;
                bit_cnt_d   = '0;
                if (scan_req || poll_evt) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    if (latch_cnt_q == LW'(NESCTRL_LATCH_TICKS - 1)) begin
                        sr1_d     = cap1;
                        sr2_d     = cap2;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = ST_CLK_HI;
                    end else begin
                        latch_cnt_d = latch_cnt_q + LW'(1);
                    end
                end
            end
            ST_CLK_HI: begin
                if (tick) begin
                    state_d = ST_CLK_LO;
                end
            end
            ST_CLK_LO: begin
                if (tick) begin
                    sr1_d = cap1;
                    sr2_d = cap2;
                    if (bit_cnt_q == BW'(NESCTRL_NBITS - 1)) begin
                        data1_d   = new1;
                        data2_d   = new2;
                        valid_d   = 1'b1;
                        changed_d = (new1 != data1_q) || (new2 != data2_q);
`ifdef NESCTRL_DEBOUNCE_EN
                        raw1_d    = cap1;
                        raw2_d    = cap2;
`endif
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = ST_CLK_HI;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pl_d   = (state_d == ST_LATCH);
        sclk_d = (state_d == ST_CLK_HI);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            poll_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            latch_cnt_q <= '0;
            bit_cnt_q   <= '0;
            sr1_q       <= '0;
            sr2_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            pl_q        <= 1'b0;
            sclk_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
`ifdef NESCTRL_DEBOUNCE_EN
            raw1_q      <= '0;
            raw2_q      <= '0;
`endif
        end else begin
            meta_q      <= {nesctrl_ctrl2_q7, nesctrl_ctrl1_q7};
            sync_q      <= meta_q;
            poll_cnt_q  <= poll_cnt_d;
            state_q     <= state_d;
            latch_cnt_q <= latch_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            pl_q        <= pl_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
`ifdef NESCTRL_DEBOUNCE_EN
            raw1_q      <= raw1_d;
            raw2_q      <= raw2_d;
`endif
        end
    end

    assign nesctrl_pl1  = pl_q;
    assign nesctrl_pl2  = pl_q;
    assign nesctrl_clk1 = sclk_q;
    assign nesctrl_clk2 = sclk_q;
    assign ctrl1_data   = data1_q;
    assign ctrl2_data   = data2_q;
    assign data_valid   = valid_q;
    assign data_changed = changed_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_nesctrl_scanner.sv
// Bench for nesctrl_scanner: 4021 pad models, scan-offset reference model,
// directed literal checks and a randomized phase.
module tb_nesctrl_scanner;

    localparam int TD   = 4;
    localparam int PD   = 200;
    localparam int SCAN = 16 * TD + 1;
`ifdef NESCTRL_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scan_req = 1'b0;
    logic q7_1, q7_2;
    logic pl1, pl2, nclk1, nclk2;
    logic [7:0] d1, d2;
    logic dv, dc, busy;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nesctrl_scanner #(
        .TICK_DIV (TD),
        .POLL_DIV (PD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .scan_req         (scan_req),
        .nesctrl_ctrl1_q7 (q7_1),
        .nesctrl_ctrl2_q7 (q7_2),
        .nesctrl_pl1      (pl1),
        .nesctrl_pl2      (pl2),
        .nesctrl_clk1     (nclk1),
        .nesctrl_clk2     (nclk2),
        .ctrl1_data       (d1),
        .ctrl2_data       (d2),
        .data_valid       (dv),
        .data_changed     (dc),
        .busy             (busy)
    );

    // 4021 pads: parallel load while PL high, shift toward Q7 on clk rise
    logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
    logic [7:0] psr1 = 8'hFF, psr2 = 8'hFF;
    logic       pc1_prev = 1'b0, pc2_prev = 1'b0;

    always @(posedge clk) begin
        if (pl1) psr1 <= ~btn1;
        else if (nclk1 && !pc1_prev) psr1 <= {1'b1, psr1[7:1]};
        if (pl2) psr2 <= ~btn2;
        else if (nclk2 && !pc2_prev) psr2 <= {1'b1, psr2[7:1]};
        pc1_prev <= nclk1;
        pc2_prev <= nclk2;
    end

    assign q7_1 = psr1[0];
    assign q7_2 = psr2[0];

    // Reference: m_t is the cycle offset inside a scan (0 = idle)
    int         m_t = 0, m_pc = 0, m_t_n;
    logic       m_evt;
    logic [7:0] m_d1 = 0, m_d2 = 0, m_r1 = 0, m_r2 = 0, m_n1, m_n2;
    logic       m_chg = 0;

    always_comb begin
        m_evt = (m_pc == PD - 1);
        m_t_n = 0;
        if (m_t != 0) m_t_n = (m_t == SCAN) ? 0 : m_t + 1;
        else if (scan_req || m_evt) m_t_n = 1;
        if (DEB) begin
            m_n1 = (btn1 == m_r1) ? btn1 : m_d1;
            m_n2 = (btn2 == m_r2) ? btn2 : m_d2;
        end else begin
            m_n1 = btn1;
            m_n2 = btn2;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_pc <= 0; m_chg <= 1'b0;
            m_d1 <= 0; m_d2 <= 0; m_r1 <= 0; m_r2 <= 0;
        end else begin
            m_pc  <= (m_pc + 1) % PD;
            m_t   <= m_t_n;
            m_chg <= 1'b0;
            if (m_t_n == SCAN) begin
                m_d1  <= m_n1;
                m_d2  <= m_n2;
                m_r1  <= btn1;
                m_r2  <= btn2;
                m_chg <= (m_n1 != m_d1) || (m_n2 != m_d2);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err < 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_clk(input int t);
        return (t >= 9) && (t <= 64) && (((t - 9) % 8) < 4);
    endfunction

    always @(negedge clk) begin
        chk("pl1", pl1, (m_t >= 1 && m_t <= 8));
        chk("pl2", pl2, (m_t >= 1 && m_t <= 8));
        chk("clk1", nclk1, exp_clk(m_t));
        chk("clk2", nclk2, exp_clk(m_t));
        chk("busy", busy, (m_t != 0));
        chk("data_valid", dv, (m_t == SCAN));
        chk("data_changed", dc, m_chg);
        chk("ctrl1_data", d1, m_d1);
        chk("ctrl2_data", d2, m_d2);
    end

    task automatic run_scan(output int lat, output int plc,
                            output int clkh, output int clkp);
        logic prev = 1'b0;
        lat = 0; plc = 0; clkh = 0; clkp = 0;
        @(negedge clk);
        @(negedge clk);
        scan_req = 1'b1;
        do begin
            @(negedge clk);
            scan_req = 1'b0;
            lat++;
            if (pl1) plc++;
            if (nclk1) clkh++;
            if (nclk1 && !prev) clkp++;
            prev = nclk1;
        end while (!dv && lat < 300);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dv && n < 400);
        chk("wait_valid_timeout", (n < 400), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, lat, plc, clkh, clkp, rises;
        logic plp;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {pl1, pl2, nclk1, nclk2, busy, dv, dc}, 0);
        chk("reset_d1", d1, 8'h00);
        chk("reset_d2", d2, 8'h00);
        rst_n = 1'b1;

        n = 0;
        while (!pl1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("first_pl_delay", n, PD);
        n = 1;
        while (!dv && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("poll_scan_len", n, SCAN);

        // Pad 1: A pressed
        btn1 = 8'h01;
        run_scan(lat, plc, clkh, clkp);
        chk("a_latency", lat, 65);
        chk("a_pl_cycles", plc, 8);
        chk("a_clk_high", clkh, 28);
        chk("a_clk_pulses", clkp, 7);
        chk("a_ctrl1", d1, DEB ? 8'h00 : 8'h01);
        chk("a_changed", dc, DEB ? 1'b0 : 1'b1);

        // Start+Right on pad 1, Up on pad 2, then a repeat scan
        btn1 = 8'h88;
        btn2 = 8'h10;
        wait_valid(n);
        run_scan(lat, plc, clkh, clkp);
        chk("b_ctrl1", d1, 8'h88);
        chk("b_ctrl2", d2, 8'h10);
        chk("b_changed", dc, DEB ? 1'b1 : 1'b0);
        run_scan(lat, plc, clkh, clkp);
        chk("b_repeat_changed", dc, 1'b0);

        // Free-running period, and a request while busy is dropped
        wait_valid(n);
        wait_valid(n);
        chk("poll_period", n, PD);
        n = 0; rises = 0; plp = 1'b0;
        while (!pl1 && n < 400) begin
            @(negedge clk);
            n++;
            if (pl1 && !plp) rises++;
            plp = pl1;
        end
        repeat (10) begin
            @(negedge clk);
            n++;
        end
        scan_req = 1'b1;
        do begin
            @(negedge clk);
            scan_req = 1'b0;
            n++;
            if (pl1 && !plp) rises++;
            plp = pl1;
        end while (!dv && n < 400);
        chk("busy_req_pl_count", rises, 1);
        chk("busy_req_period", n, PD);

        // Reset during the third clk-high phase
        clkp = 0; plp = 1'b0; n = 0;
        @(negedge clk);
        @(negedge clk);
        scan_req = 1'b1;
        while (clkp < 3 && n < 200) begin
            @(negedge clk);
            scan_req = 1'b0;
            n++;
            if (nclk1 && !plp) clkp++;
            plp = nclk1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {pl1, pl2, nclk1, nclk2, busy, dv, dc}, 0);
        chk("rst_mid_d1", d1, 8'h00);
        chk("rst_mid_d2", d2, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        btn1 = 8'h21;
        btn2 = 8'h42;
        run_scan(lat, plc, clkh, clkp);
        chk("post_rst_latency", lat, 65);
        chk("post_rst_ctrl1", d1, DEB ? 8'h00 : 8'h21);
        run_scan(lat, plc, clkh, clkp);
        chk("post_rst2_ctrl1", d1, 8'h21);
        chk("post_rst2_ctrl2", d2, 8'h42);

        // Single-scan glitch on pad 1
        btn1 = 8'h00;
        btn2 = 8'h00;
        wait_valid(n);
        wait_valid(n);
        btn1 = 8'h01;
        run_scan(lat, plc, clkh, clkp);
        chk("glitch_ctrl1", d1, DEB ? 8'h00 : 8'h01);
        btn1 = 8'h00;
        run_scan(lat, plc, clkh, clkp);
        chk("glitch_end_ctrl1", d1, 8'h00);

        // Randomized requests and idle-time button changes
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            scan_req = ($urandom_range(0, 39) == 0);
            if (m_t == 0 && $urandom_range(0, 9) == 0) begin
                btn1 = 8'($urandom);
                btn2 = 8'($urandom);
            end
        end
        scan_req = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/nesctrl_scanner.md
# nesctrl_scanner

Serial poll controller for the two NES gamepads on the board. It generates the latch (PL) and shift-clock waveforms for both 4021 shift registers and samples their Q7 lines. It publishes one active-high 8-bit button word per pad to the system's peripheral side. It sits between the NESCTRL pads and the CPU-visible register bank and replaces ad-hoc bit-banging from software.

## Interface
- TICK_DIV, 600: clk cycles per protocol half-period. 6 µs at 100 MHz. Minimum 4.
- POLL_DIV, 1666667: clk cycles between automatic scans. 60 Hz at 100 MHz. Must exceed 16*TICK_DIV+2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- scan_req  in  1  single-cycle request to start a scan immediately.
- nesctrl_ctrl1_q7, nesctrl_ctrl2_q7  in  1  serial data from pads. Asynchronous, active-low buttons.
- nesctrl_pl1, nesctrl_pl2  out  1  parallel-load pulse, active-high.
- nesctrl_clk1, nesctrl_clk2  out  1  shift clock. Idles low.
- ctrl1_data, ctrl2_data  out  8  published buttons, active-high. Bit 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- data_valid  out  1  one-cycle pulse when a scan completes.
- data_changed  out  1  one-cycle pulse, coincident with data_valid, when either published word changed.
- busy  out  1  high from scan start until the DONE cycle ends.

## Operation
- Each q7 input passes through a 2-flop synchronizer before sampling.
- The tick generator counts 0..TICK_DIV-1 and emits a 1-cycle tick at wrap. It is held at 0 while the FSM is in IDLE, so phase 1 starts aligned.
- The poll counter runs free from reset over 0..POLL_DIV-1. Wrap produces poll_evt.
- FSM states: IDLE, LATCH, CLK_HI, CLK_LO, DONE.
- IDLE → LATCH on scan_req or poll_evt. If both arrive in the same cycle, one scan runs. Requests and poll_evt that arrive while busy are dropped and not queued.
- LATCH lasts 2 ticks with pl1/pl2 high. At its last tick, shift registers capture bit 0 as ~q7_sync.
- CLK_HI lasts 1 tick with clk1/clk2 high. The pad shifts on the rising edge.
- CLK_LO lasts 1 tick with clocks low. At its last tick the next bit is captured. The bit counter increments.
- After bit 7 is captured the FSM enters DONE; otherwise it returns to CLK_HI. Seven clock pulses are issued in total.
- DONE lasts 1 cycle. It updates ctrl1_data and ctrl2_data, pulses data_valid, and pulses data_changed if the new words differ from the old ones. Then the FSM returns to IDLE.
- Both pads are scanned in lockstep. pl1/pl2 are identical, and so are clk1/clk2.
- Reset, asserted at any time including mid-scan: all outputs are 0 immediately, the FSM goes to IDLE, and the counters clear. The first scan after release starts on scan_req or on the first poll_evt, which comes POLL_DIV cycles after release.

## Timing
- Scan length from the start cycle to the data_valid cycle is 16*TICK_DIV+1 cycles.
- PL high time is exactly 2*TICK_DIV cycles.
- Each clk high time and each clk low time is TICK_DIV cycles.
- Response latency: the scan_req cycle is followed by LATCH (pl high) on the next cycle.
- Synchronizer latency is 2 cycles. Sampling happens at least TICK_DIV-1 cycles after the last edge, so the sampled value is stable.
- data_valid, data_changed and the data update all occur in the same cycle. Data holds until the next DONE.

## Configuration
- NESCTRL_DEBOUNCE_EN defined:
  - Raw scan words are held in a shadow register.
  - In DONE, a published word updates only if its raw word equals the previous raw word, i.e. it is stable across two consecutive scans.
  - data_valid still pulses every scan.
- NESCTRL_DEBOUNCE_EN undefined: the raw word is published directly in every DONE. No shadow registers are present.

## Structure
- Package nesctrl_pkg holds:
  - the FSM state encoding;
  - NESCTRL_NBITS=8 and NESCTRL_LATCH_TICKS=2;
  - the button bit-index constants (BTN_A … BTN_RIGHT).
- Sub-module nesctrl_tick_gen is the prescaler. Inputs are clk, rst_n and a clear. Output is a tick. TICK_DIV is a parameter.
- The FSM, the synchronizers and the poll counter live in nesctrl_scanner.

## Test plan
All scenarios use TICK_DIV=4 and POLL_DIV=200 unless stated. Pad models shift on the rising edge of the clock.
- Reset: hold rst_n low → all outputs 0. Release → no pl activity for 200 cycles, then the first pl.
- scan_req, pad1 driving 0xFE (A pressed) → pl high 8 cycles, 7 clk pulses each 4 high and 4 low. data_valid 65 cycles after scan_req, ctrl1_data=0x01, data_changed=1.
- Pad1 Start+Right and pad2 Up → ctrl1_data=0x88 and ctrl2_data=0x10 in the same DONE. A repeated identical scan gives data_changed=0.
- Free-running with no scan_req → data_valid every 200 cycles. A scan_req pulsed while busy adds no extra pl pulse.
- rst_n low during the 3rd clk-high phase → pl and clk low in the same cycle, data 0. After release, the next scan completes normally with correct data.
- Single-scan glitch 0x00→0x01→0x00 on pad1:
  - with NESCTRL_DEBOUNCE_EN, ctrl1_data stays 0x00;
  - without it, ctrl1_data shows 0x01 for one scan.
